ps2_host_tx: RTL and testbench

- Host-to-device transmitter for the PS/2 port. It is the command path paired with the existing ps2_host scan-code receiver.
- Accepts one command byte per valid/ready handshake (e.g. 0xED set-LEDs, 0xFF reset). It inhibits the bus, issues a request-to-send, and shifts the byte out on device-generated clocks with odd parity and stop bit. It then checks the device ACK.
- Drives open-drain enables only. Top level ties the pins: PS2_CLK = clk_oe ? 0 : 'z'.
- busy gates the receiver so the receiver ignores the frame and its ACK.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, constants and parity helper for the PS/2 host blocks
package ps2_pkg;

  // START is folded into SHIFT with the bit counter at zero
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity over the eight data bits
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and status bundle for the PS/2 host transmitter
interface ps2_host_tx_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  // master issues command bytes, slave is the transmitter
  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, ack_err, timeout_err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop synchronizer with falling-edge detect for a PS/2 line
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines are pulled high, so every stage resets to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK and timeout checks
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ   = 50,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe,
  ps2_host_tx_if.slave    bus
);

  localparam int INHIBIT_CYC = CLK_FREQ * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_FREQ * TIMEOUT_US;
  localparam int MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW          = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] INH_DATA_LAST = CW'(INHIBIT_CYC - 2);
  localparam logic [CW-1:0] INH_LAST      = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST       = CW'(TIMEOUT_CYC - 1);

  ps2_tx_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [9:0]    frame_q;
  logic          clk_oe_q;
  logic          data_oe_q;
  logic          done_q;
  logic          ack_err_q;
  logic          timeout_q;
  logic          nack_q;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (ps2_clk),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (ps2_data),
    .level_o (data_level),
    .fall_o  (data_fall_unused)
  );

  // Frame sequencer: inhibit, request-to-send, shift on device clocks, check ACK, wait for idle bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      if ((state_q inside {SHIFT, ACK, WAIT_IDLE}) && (cnt_q == TO_LAST)) begin
        // Device went quiet: free the bus; a NACKed frame already reported its error
        state_q   <= IDLE;
        cnt_q     <= '0;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        timeout_q <= ~nack_q;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.tx_valid) begin
              frame_q  <= {1'b1, ps2_odd_parity(bus.tx_data), bus.tx_data};
              cnt_q    <= '0;
              nack_q   <= 1'b0;
              clk_oe_q <= 1'b1;
              state_q  <= INHIBIT;
            end
          end
          INHIBIT: begin
            // Falls seen here are our own clock hold and are ignored
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == INH_DATA_LAST) begin
              data_oe_q <= 1'b1;
            end
            if (cnt_q == INH_LAST) begin
              clk_oe_q <= 1'b0;
              cnt_q    <= '0;
              bit_q    <= '0;
              state_q  <= SHIFT;
            end
          end
          SHIFT: begin
            if (clk_fall) begin
              cnt_q     <= '0;
              data_oe_q <= ~frame_q[0];
              frame_q   <= {1'b0, frame_q[9:1]};
              bit_q     <= bit_q + 4'd1;
              if (bit_q == 4'd9) begin
                state_q <= ACK;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ACK: begin
            if (clk_fall) begin
              cnt_q     <= '0;
              nack_q    <= data_level;
              ack_err_q <= data_level;
              state_q   <= WAIT_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          WAIT_IDLE: begin
            cnt_q <= clk_fall ? '0 : cnt_q + CW'(1);
            if (clk_level && data_level) begin
              done_q  <= ~nack_q;
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign ps2_clk_oe      = clk_oe_q;
  assign ps2_data_oe     = data_oe_q;
  assign bus.tx_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  logic clk;
  logic rst_n;
  logic dev_clk;
  logic dev_data;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic ps2_clk_line;
  logic ps2_data_line;

  int n_checks;
  int n_fail;
  int n_done;
  int n_ack;
  int n_to;
  int d0;
  int a0;
  int t0;

  ps2_host_tx_if bus ();

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ   (50),
    .INHIBIT_US (1),
    .TIMEOUT_US (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk_line),
    .ps2_data    (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count status pulses (one per sampled high cycle, so stretched pulses show up)
  initial begin
    n_done = 0;
    n_ack  = 0;
    n_to   = 0;
  end
  always @(negedge clk) begin
    if (bus.done === 1'b1) n_done++;
    if (bus.ack_err === 1'b1) n_ack++;
    if (bus.timeout_err === 1'b1) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    d0 = n_done;
    a0 = n_ack;
    t0 = n_to;
  endtask

  task automatic start_byte(input logic [7:0] b);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(posedge clk);
  endtask

  // Device side of one frame: sample start while clock idles, then bits on rising edges, then ACK clock
  task automatic dev_frame(input string tag, input bit give_ack, output logic [10:0] f);
    int g;
    g = 0;
    f = '0;
    while (!(bus.busy && !ps2_clk_oe) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_release"}, 32'(g < 500), 32'd1);
    repeat (20) @(negedge clk);
    f[0] = ps2_data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      f[i] = ps2_data_line;
      if (i == 10 && give_ack) dev_data = 1'b0;
      repeat (20) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic finish_frame(input string tag, input int ed, input int ea, input int et);
    int g;
    g = 0;
    while (!bus.tx_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_idle"}, 32'(g < 200), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_done"}, 32'(n_done - d0), 32'(ed));
    check({tag, "_ackerr"}, 32'(n_ack - a0), 32'(ea));
    check({tag, "_timeout"}, 32'(n_to - t0), 32'(et));
    check({tag, "_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] f;
    int k;
    int cnt_hi;
    int first_d;
    int g;

    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pulses", {29'd0, bus.done, bus.ack_err, bus.timeout_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);

    // 0xED: inhibit timing, frame content, ACK -> done
    snap();
    start_byte(8'hED);
    cnt_hi  = 0;
    first_d = 0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.tx_valid = 1'b0;
      if (ps2_clk_oe) cnt_hi++;
      if (ps2_data_oe && first_d == 0) first_d = k;
    end
    check("ed_inhibit_len", 32'(cnt_hi), 32'd50);
    check("ed_data_oe_cycle", 32'(first_d), 32'd50);
    check("ed_busy", 32'(bus.busy), 32'd1);
    dev_frame("ed", 1'b1, f);
    check("ed_frame", 32'(f), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    finish_frame("ed", 1, 0, 0);

    // 0x00: parity 1
    snap();
    start_byte(8'h00);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    dev_frame("b00", 1'b1, f);
    check("b00_frame", 32'(f), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
    finish_frame("b00", 1, 0, 0);

    // 0x01: parity 0
    snap();
    start_byte(8'h01);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    dev_frame("b01", 1'b1, f);
    check("b01_frame", 32'(f), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
    finish_frame("b01", 1, 0, 0);

    // Missing ACK -> ack_err only
    snap();
    start_byte(8'hA5);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    dev_frame("nack", 1'b0, f);
    check("nack_frame", 32'(f), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
    finish_frame("nack", 0, 1, 0);

    // Device never clocks -> timeout 100 cycles after the clock is released
    snap();
    start_byte(8'h3C);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    g = 0;
    while (!(bus.busy && !ps2_clk_oe) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("to_release", 32'(g < 500), 32'd1);
    k = 1;
    while (!bus.timeout_err && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("to_gap", 32'(k - 1), 32'd100);
    check("to_ready", 32'(bus.tx_ready), 32'd1);
    check("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    finish_frame("to", 0, 0, 1);

    // tx_valid held through a frame: only 0xF4 goes out, 0x55 follows after done
    snap();
    start_byte(8'hF4);
    @(negedge clk);
    bus.tx_data = 8'h55;
    dev_frame("f4", 1'b1, f);
    check("f4_frame", 32'(f), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    g = 0;
    while (!bus.done && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("f4_done_seen", 32'(g < 200), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("b55_accepted", 32'(bus.busy), 32'd1);
    dev_frame("b55", 1'b1, f);
    check("b55_frame", 32'(f), 32'({1'b1, 1'b1, 8'h55, 1'b0}));
    finish_frame("f4_55", 2, 0, 0);

    // Reset during bit 4 of 0xFF, then a clean 0xFF
    snap();
    start_byte(8'hFF);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    g = 0;
    while (!(bus.busy && !ps2_clk_oe) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("rs_release", 32'(g < 500), 32'd1);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("rs_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rs_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rs_ready", 32'(bus.tx_ready), 32'd1);
    rst_n   = 1'b1;
    dev_clk = 1'b1;
    repeat (200) @(negedge clk);
    check("rs_no_pulses", 32'((n_done - d0) + (n_ack - a0) + (n_to - t0)), 32'd0);
    snap();
    start_byte(8'hFF);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    dev_frame("ff", 1'b1, f);
    check("ff_frame", 32'(f), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
    finish_frame("ff", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
